hacd_irq_regs: RTL and testbench
================================

Name: hacd_irq_regs

Overview:
- Parametrised successor to the HACD control-register block.
- Provides a register-interface slave with N_IRQ interrupt channels (sticky status, enable mask, write-1-to-clear, software trigger) and a free-page low-watermark monitor with a debounce counter driving alert_oom_o.
- Sits between the chipset register bus and hacd_core. Core event pulses arrive here; level interrupts and control bits leave here.

Parameters:
- N_IRQ, 4: number of hardware/software interrupt channels (1..16).
- CNT_W, 32: width of the free-page count and the LOW_WM register (1..32).
- HOLD_CYCLES, 16: consecutive below-watermark cycles required to raise OOM (>=1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  hacd_pkg::reg_intf_req_a32_d32  register request (valid, write, addr, wdata, wstrb)
- resp_o  out  hacd_pkg::reg_intf_resp_d32  register response (ready, rdata, error)
- evt_i  in  N_IRQ  one-cycle event pulses from hacd_core, one per channel
- free_pages_i  in  CNT_W  current free-page count from hacd_core
- irq_o  out  N_IRQ+1  level interrupts: status & enable; bit N_IRQ is OOM
- inactive_ctrl_o  out  1  CTRL.INACTIVE level
- alert_oom_o  out  1  debounced below-watermark alert

Behaviour:
- Reset (async, rst_ni=0):
  - All registers are 0: resp_o.ready=0, rdata=0, error=0, irq_o=0, inactive_ctrl_o=0, alert_oom_o=0.
  - Handshake FSM returns to IDLE.
- Register map, byte offsets from addr[7:0]; addr[1:0] ignored; addr[31:8] not decoded:
  - 0x00 CTRL: [N_IRQ-1:0] SWTRIG, write-1 pulse, reads 0. [31] INACTIVE, RW.
  - 0x04 LOW_WM: RW, [CNT_W-1:0]; upper bits read 0.
  - 0x08 IRQ_STATUS: [N_IRQ:0], write-1-to-clear.
  - 0x0C IRQ_ENABLE: [N_IRQ:0], RW.
  - 0x10 FREE_PAGES: RO, free_pages_i sampled at accept.
  - 0x14 EVT_CNT: 16-bit saturating count of all evt_i/SWTRIG set events. Any write clears it.
  - Any other offset: error=1, rdata=0, no state change.
- wstrb: RW and W1C fields honour byte enables. SWTRIG uses byte 0 and byte 1 strobes only.
- Handshake FSM:
  - IDLE -> ACK when req_i.valid=1. The access takes effect on the accept edge.
  - In ACK, resp_o.ready=1 for exactly one cycle with registered rdata/error. ACK -> IDLE unconditionally.
  - Master holds valid until ready. valid still high in IDLE after ACK is a new access.
  - Latency: ready 1 cycle after accept; back-to-back throughput is one access per 2 cycles.
- Status update, per bit per cycle: next = (cur & ~w1c_clear) | evt_i | swtrig.
  - Set wins over simultaneous clear.
  - Events while enable=0 still set status.
- irq_o = IRQ_STATUS & IRQ_ENABLE, registered (1-cycle delay from status).
- EVT_CNT:
  - Increments by popcount of bits newly set this cycle, including re-sets of an already-set bit.
  - Saturates at 0xFFFF.
  - A clear-write in the same cycle as events wins (result 0).
- Watermark monitor:
  - below = (LOW_WM != 0) && (free_pages_i < LOW_WM), unsigned compare.
  - hold counter is reset to 0 when below=0. It increments when below=1 and saturates at HOLD_CYCLES.
  - alert_oom_o = 1 when the counter reaches HOLD_CYCLES. It drops in the cycle after below=0.
  - STATUS[N_IRQ] is set on the rising edge of alert_oom_o only. It is sticky until W1C.
  - Writing LOW_WM mid-count does not reset the counter; the counter follows the new below value.
  - LOW_WM=0 disables the monitor.
- Reset mid-access: FSM to IDLE, no response issued; the master must reissue.

Decomposition:
- hacd_pkg:
  - register offset localparams (HACD_IRQ_CTRL_OFS .. HACD_IRQ_EVTCNT_OFS);
  - CTRL_INACTIVE_BIT=31;
  - a 2-state enum hacd_irq_fsm_e {IDLE, ACK}.
- One sub-module, hacd_wm_monitor:
  - parameters CNT_W, HOLD_CYCLES;
  - inputs clk_i, rst_ni, free_pages_i, low_wm_i;
  - outputs alert_o, alert_rise_o.

Test Plan:
- Reset, then read all 6 registers -> CTRL/LOW_WM/STATUS/ENABLE/EVT_CNT = 0, FREE_PAGES = free_pages_i, ready exactly 1 cycle after valid, error=0. Read 0x18 -> error=1, rdata=0.
- Pulse evt_i[2] with ENABLE=0 -> STATUS=0x4, irq_o=0. Write ENABLE=0x4 -> irq_o[2]=1 next cycle. W1C 0x4 -> irq_o=0. EVT_CNT=1.
- W1C STATUS[1] in the same cycle as evt_i[1] pulse -> STATUS[1] stays 1; EVT_CNT increments.
- LOW_WM=100, free_pages_i=99 for 15 cycles then 100 -> no alert. Then 99 held 16 cycles -> alert_oom_o=1 at cycle 16, STATUS[4]=1. Then free_pages_i=100 -> alert 0 next cycle, STATUS[4] stays 1.
- Write CTRL=0x8000_0003 with wstrb=0x9 -> INACTIVE=1, STATUS[1:0] set, CTRL reads 0x8000_0000. Write with wstrb=0x1 only -> INACTIVE unchanged.
- Drive 0xFFFF+3 events -> EVT_CNT=0xFFFF. Write 0x14 -> 0. Assert rst_ni low during ACK -> ready=0 immediately, all registers 0.

Source files
------------

// File: rtl/hacd_pkg.sv
// Shared types, register offsets and handshake state encoding for the HACD
// interrupt/control register block.
package hacd_pkg;

   typedef struct packed {
      logic        valid;
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } reg_intf_req_a32_d32;

   typedef struct packed {
      logic        ready;
      logic [31:0] rdata;
      logic        error;
   } reg_intf_resp_d32;

   localparam logic [7:0] HACD_IRQ_CTRL_OFS   = 8'h00;
   localparam logic [7:0] HACD_IRQ_LOWWM_OFS  = 8'h04;
   localparam logic [7:0] HACD_IRQ_STATUS_OFS = 8'h08;
   localparam logic [7:0] HACD_IRQ_ENABLE_OFS = 8'h0C;
   localparam logic [7:0] HACD_IRQ_FREE_OFS   = 8'h10;
   localparam logic [7:0] HACD_IRQ_EVTCNT_OFS = 8'h14;

   localparam int CTRL_INACTIVE_BIT = 31;

   typedef enum logic {IDLE = 1'b0, ACK = 1'b1} hacd_irq_fsm_e;

   // Expands the four byte strobes into a per-bit write mask.
   function automatic logic [31:0] strb_mask(input logic [3:0] wstrb);
      return {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
   endfunction

endpackage

// File: rtl/hacd_wm_monitor.sv
// Free-page low-watermark monitor: raises alert_o after HOLD_CYCLES
// consecutive cycles with free_pages_i below a non-zero low_wm_i.
module hacd_wm_monitor #(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned HOLD_CYCLES = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [CNT_W-1:0] free_pages_i,
   input  logic [CNT_W-1:0] low_wm_i,
   output logic             alert_o,
   output logic             alert_rise_o
);

   localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_CNT = HW'(HOLD_CYCLES);

   logic          below;
   logic [HW-1:0] hold_cnt_q;
   logic          alert_q;

   // A zero watermark disables the monitor entirely.
   assign below = (low_wm_i != '0) && (free_pages_i < low_wm_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hold_cnt_q <= '0;
         alert_q    <= 1'b0;
      end else begin
         alert_q <= alert_o;
         if (!below)
            hold_cnt_q <= '0;
         else if (hold_cnt_q != HOLD_CNT)
            hold_cnt_q <= hold_cnt_q + 1'b1;
      end
   end

   assign alert_o      = (hold_cnt_q == HOLD_CNT);
   assign alert_rise_o = alert_o & ~alert_q;

endmodule

// File: rtl/hacd_irq_regs.sv
// Register slave for the HACD core: sticky interrupt status with enable mask,
// W1C and software trigger, event counter, and the low-watermark OOM alert.
module hacd_irq_regs
   import hacd_pkg::*;
#(
   parameter int unsigned N_IRQ       = 4,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned HOLD_CYCLES = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  reg_intf_req_a32_d32 req_i,
   output reg_intf_resp_d32    resp_o,
   input  logic [N_IRQ-1:0]    evt_i,
   input  logic [CNT_W-1:0]    free_pages_i,
   output logic [N_IRQ:0]      irq_o,
   output logic                inactive_ctrl_o,
   output logic                alert_oom_o,
   output logic                dbg_state_o
);

   // Handshake: a request is accepted on the edge where req_i.valid=1 in IDLE;
   // resp_o.ready is high for exactly the following cycle, then back to IDLE.
   hacd_irq_fsm_e    state_q;
   logic             ready_q, error_q;
   logic [31:0]      rdata_q;

   logic [N_IRQ:0]   status_q, enable_q, irq_q;
   logic [CNT_W-1:0] low_wm_q;
   logic             inactive_q;
   logic [15:0]      evt_cnt_q;

   logic             accept, wr;
   logic [7:0]       ofs;
   logic [31:0]      bmask;
   logic             rd_hit;
   logic [31:0]      rd_val;
   logic [N_IRQ-1:0] swtrig;
   logic [N_IRQ:0]   w1c, status_d;
   logic [4:0]       n_set;
   logic [16:0]      cnt_sum;
   logic             alert, alert_rise;

   assign accept = (state_q == IDLE) && req_i.valid;
   assign wr     = accept && req_i.write;
   assign ofs    = {req_i.addr[7:2], 2'b00};
   assign bmask  = strb_mask(req_i.wstrb);

   always_comb begin
      rd_hit = 1'b1;
      rd_val = '0;
      case (ofs)
         HACD_IRQ_CTRL_OFS:   rd_val[CTRL_INACTIVE_BIT] = inactive_q;
         HACD_IRQ_LOWWM_OFS:  rd_val[CNT_W-1:0] = low_wm_q;
         HACD_IRQ_STATUS_OFS: rd_val[N_IRQ:0] = status_q;
         HACD_IRQ_ENABLE_OFS: rd_val[N_IRQ:0] = enable_q;
         HACD_IRQ_FREE_OFS:   rd_val[CNT_W-1:0] = free_pages_i;
         HACD_IRQ_EVTCNT_OFS: rd_val[15:0] = evt_cnt_q;
         default:             rd_hit = 1'b0;
      endcase
   end

   // N_IRQ <= 16, so the software trigger only ever sees byte 0/1 strobes.
   assign swtrig = (wr && ofs == HACD_IRQ_CTRL_OFS) ?
                   (req_i.wdata[N_IRQ-1:0] & bmask[N_IRQ-1:0]) : '0;
   assign w1c    = (wr && ofs == HACD_IRQ_STATUS_OFS) ?
                   (req_i.wdata[N_IRQ:0] & bmask[N_IRQ:0]) : '0;

   // Set wins over a simultaneous W1C of the same bit.
   assign status_d = (status_q & ~w1c) | {alert_rise, evt_i | swtrig};
   assign n_set    = 5'($countones(evt_i | swtrig));
   assign cnt_sum  = {1'b0, evt_cnt_q} + {12'b0, n_set};

   hacd_wm_monitor #(
      .CNT_W       (CNT_W),
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_wm_monitor (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .free_pages_i (free_pages_i),
      .low_wm_i     (low_wm_q),
      .alert_o      (alert),
      .alert_rise_o (alert_rise)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         ready_q    <= 1'b0;
         rdata_q    <= '0;
         error_q    <= 1'b0;
         status_q   <= '0;
         enable_q   <= '0;
         irq_q      <= '0;
         low_wm_q   <= '0;
         inactive_q <= 1'b0;
         evt_cnt_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_i.valid) begin
                  state_q <= ACK;
                  ready_q <= 1'b1;
                  rdata_q <= (req_i.write || !rd_hit) ? 32'h0 : rd_val;
                  error_q <= !rd_hit;
               end
            end
            ACK: begin
               state_q <= IDLE;
               ready_q <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase

         status_q <= status_d;
         irq_q    <= status_q & enable_q;

         if (wr && ofs == HACD_IRQ_EVTCNT_OFS)
            evt_cnt_q <= '0;
         else
            evt_cnt_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

         if (wr && ofs == HACD_IRQ_CTRL_OFS && req_i.wstrb[3])
            inactive_q <= req_i.wdata[CTRL_INACTIVE_BIT];
         if (wr && ofs == HACD_IRQ_LOWWM_OFS)
            low_wm_q <= (low_wm_q & ~bmask[CNT_W-1:0]) |
                        (req_i.wdata[CNT_W-1:0] & bmask[CNT_W-1:0]);
         if (wr && ofs == HACD_IRQ_ENABLE_OFS)
            enable_q <= (enable_q & ~bmask[N_IRQ:0]) |
                        (req_i.wdata[N_IRQ:0] & bmask[N_IRQ:0]);
      end
   end

   assign resp_o.ready    = ready_q;
   assign resp_o.rdata    = rdata_q;
   assign resp_o.error    = error_q;
   assign irq_o           = irq_q;
   assign inactive_ctrl_o = inactive_q;
   assign alert_oom_o     = alert;
   assign dbg_state_o     = state_q;

   logic unused_req_bits;
   assign unused_req_bits = ^{req_i.addr[31:8], req_i.addr[1:0], req_i.wdata, bmask};

endmodule

// File: tb/tb_hacd_irq_regs.sv
// Bench for hacd_irq_regs: directed scenarios plus randomized traffic, checked
// against a cycle-stepped behavioural model of the register block.
module tb_hacd_irq_regs;
   import hacd_pkg::*;

   localparam int N_IRQ = 4;
   localparam int CNT_W = 32;
   localparam int HOLD  = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   reg_intf_req_a32_d32 req;
   reg_intf_resp_d32    resp;
   logic [N_IRQ-1:0]    evt;
   logic [CNT_W-1:0]    free;
   logic [N_IRQ:0]      irq;
   logic                inactive, alert, dbg_state;

   hacd_irq_regs #(.N_IRQ(N_IRQ), .CNT_W(CNT_W), .HOLD_CYCLES(HOLD)) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .req_i           (req),
      .resp_o          (resp),
      .evt_i           (evt),
      .free_pages_i    (free),
      .irq_o           (irq),
      .inactive_ctrl_o (inactive),
      .alert_oom_o     (alert),
      .dbg_state_o     (dbg_state)
   );

   // ---------------- reference model ----------------
   logic [31:0] m_status, m_enable, m_irq, m_lowwm;
   int unsigned m_evtcnt, m_run;
   bit          m_inactive, m_ack, m_alert_d;
   bit          rand_mode;
   logic [31:0] exp_q[$];
   logic [0:0]  err_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_status = 0; m_enable = 0; m_irq = 0; m_lowwm = 0;
      m_evtcnt = 0; m_run = 0; m_inactive = 0; m_ack = 0; m_alert_d = 0;
      exp_q.delete();
      err_q.delete();
   endtask

   // Advance one clock: step the model with the inputs present at the edge,
   // then compare every observable output 1 time unit after the edge.
   task automatic tick();
      logic [31:0] mask, sw, clr, rdv, n_status;
      bit          acc, wr, hit, below, rise;
      int          off;
      int unsigned n_cnt;
      if (rand_mode) begin
         evt = ($urandom_range(0, 7) == 0) ? N_IRQ'($urandom) : '0;
         if ($urandom_range(0, 15) == 0)
            free = ($urandom_range(0, 2) != 0) ? m_lowwm - 1 : m_lowwm;
      end
      acc  = req.valid && !m_ack;
      wr   = acc && req.write;
      mask = {{8{req.wstrb[3]}}, {8{req.wstrb[2]}}, {8{req.wstrb[1]}}, {8{req.wstrb[0]}}};
      off  = int'(req.addr[7:2]);
      hit  = (off <= 5);
      case (off)
         0: rdv = {m_inactive, 31'b0};
         1: rdv = m_lowwm;
         2: rdv = m_status;
         3: rdv = m_enable;
         4: rdv = free;
         5: rdv = m_evtcnt;
         default: rdv = 0;
      endcase
      sw  = (wr && off == 0) ? (req.wdata & mask & ((32'd1 << N_IRQ) - 1)) : 0;
      clr = (wr && off == 2) ? (req.wdata & mask & ((32'd1 << (N_IRQ + 1)) - 1)) : 0;
      below = (m_lowwm != 0) && (free < m_lowwm);
      rise  = (m_run == HOLD) && !m_alert_d;
      n_status = (m_status & ~clr) | 32'(evt) | sw | (32'(rise) << N_IRQ);
      n_cnt = m_evtcnt + $countones(32'(evt) | sw);
      if (n_cnt > 32'hFFFF) n_cnt = 32'hFFFF;
      if (wr && off == 5) n_cnt = 0;

      m_irq     = m_status & m_enable;
      m_alert_d = (m_run == HOLD);
      m_run     = below ? ((m_run < HOLD) ? m_run + 1 : HOLD) : 0;
      m_status  = n_status;
      m_evtcnt  = n_cnt;
      if (wr && off == 0 && req.wstrb[3]) m_inactive = req.wdata[31];
      if (wr && off == 1) m_lowwm = (m_lowwm & ~mask) | (req.wdata & mask);
      if (wr && off == 3) m_enable = ((m_enable & ~mask) | (req.wdata & mask)) & ((32'd1 << (N_IRQ + 1)) - 1);
      if (acc) begin
         exp_q.push_back((req.write || !hit) ? 32'h0 : rdv);
         err_q.push_back(!hit);
      end
      m_ack = acc;

      @(posedge clk);
      #1;
      check("ready", 32'(resp.ready), 32'(m_ack));
      check("fsm_state", 32'(dbg_state), 32'(m_ack));
      check("irq", 32'(irq), m_irq);
      check("alert", 32'(alert), 32'(m_run == HOLD));
      check("inactive", 32'(inactive), 32'(m_inactive));
      if (resp.ready) begin
         if (exp_q.size() == 0) begin
            check("rsp_unexpected", 32'(1), 32'(0));
         end else begin
            check("rdata", resp.rdata, exp_q.pop_front());
            check("error", 32'(resp.error), 32'(err_q.pop_front()));
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic reg_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, output logic [31:0] rdata, output logic err);
      req.valid = 1'b1;
      req.write = wr;
      req.addr  = addr;
      req.wdata = wdata;
      req.wstrb = wstrb;
      tick();
      rdata = resp.rdata;
      err   = resp.error;
      req.valid = 1'b0;
      req.write = 1'b0;
      tick();
   endtask

   task automatic reg_wr(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
      logic [31:0] d;
      logic        e;
      reg_access(1'b1, addr, wdata, wstrb, d, e);
   endtask

   task automatic reg_rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      logic        e;
      reg_access(1'b0, addr, 32'h0, 4'h0, d, e);
      check(tag, d, exp);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] d;
      logic        e;
      int          off;
      rand_mode = 0;
      rst_n = 1'b0;
      req   = '0;
      evt   = '0;
      free  = 32'd500;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(resp.ready), 32'h0);
      check("rst_rdata", resp.rdata, 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_alert", 32'(alert), 32'h0);
      rst_n = 1'b1;

      // Reset values of every register, response one cycle after valid
      reg_rd_chk("rd_ctrl", 32'h00, 32'h0);
      reg_rd_chk("rd_lowwm", 32'h04, 32'h0);
      reg_rd_chk("rd_status", 32'h08, 32'h0);
      reg_rd_chk("rd_enable", 32'h0C, 32'h0);
      reg_rd_chk("rd_free", 32'h10, 32'd500);
      reg_rd_chk("rd_evtcnt", 32'h14, 32'h0);
      reg_access(1'b0, 32'h18, 32'h0, 4'h0, d, e);
      check("bad_ofs_err", 32'(e), 32'h1);
      check("bad_ofs_rdata", d, 32'h0);

      // Event while disabled, then enable, then W1C
      evt = 4'b0100; tick(); evt = '0;
      reg_rd_chk("sts_evt2", 32'h08, 32'h4);
      check("irq_masked", 32'(irq), 32'h0);
      reg_wr(32'h0C, 32'h4, 4'hF);
      check("irq_enabled", 32'(irq), 32'h4);
      reg_wr(32'h08, 32'h4, 4'hF);
      check("irq_cleared", 32'(irq), 32'h0);
      reg_rd_chk("evtcnt_1", 32'h14, 32'h1);

      // W1C colliding with a set of the same bit
      evt = 4'b0010; tick(); evt = '0;
      req.valid = 1'b1; req.write = 1'b1; req.addr = 32'h08; req.wdata = 32'h2; req.wstrb = 4'hF;
      evt = 4'b0010; tick(); evt = '0;
      req.valid = 1'b0; req.write = 1'b0; tick();
      reg_rd_chk("set_wins", 32'h08, 32'h2);
      reg_rd_chk("evtcnt_3", 32'h14, 32'h3);
      reg_wr(32'h08, 32'h1F, 4'hF);

      // Watermark debounce
      free = 32'd100;
      reg_wr(32'h04, 32'd100, 4'hF);
      free = 32'd99;
      repeat (15) tick();
      free = 32'd100; tick();
      check("wm_short_run", 32'(alert), 32'h0);
      free = 32'd99;
      repeat (15) tick();
      check("wm_cyc15", 32'(alert), 32'h0);
      tick();
      check("wm_cyc16", 32'(alert), 32'h1);
      tick();
      reg_rd_chk("wm_status", 32'h08, 32'h10);
      free = 32'd100; tick();
      check("wm_drop", 32'(alert), 32'h0);
      reg_rd_chk("wm_sticky", 32'h08, 32'h10);
      reg_wr(32'h08, 32'h1F, 4'hF);

      // CTRL byte strobes
      reg_wr(32'h00, 32'h8000_0003, 4'h9);
      check("inactive_set", 32'(inactive), 32'h1);
      reg_rd_chk("ctrl_rd", 32'h00, 32'h8000_0000);
      reg_rd_chk("swtrig_sts", 32'h08, 32'h3);
      reg_wr(32'h00, 32'h0000_0000, 4'h1);
      check("inactive_kept", 32'(inactive), 32'h1);
      reg_wr(32'h00, 32'h0000_0000, 4'h8);
      check("inactive_clr", 32'(inactive), 32'h0);

      // Event counter saturation
      reg_wr(32'h14, 32'h0, 4'hF);
      evt = '1;
      repeat (16384) tick();
      evt = 4'b0011; tick(); evt = '0;
      reg_rd_chk("evtcnt_sat", 32'h14, 32'hFFFF);
      reg_wr(32'h14, 32'h0, 4'h0);
      reg_rd_chk("evtcnt_clr", 32'h14, 32'h0);
      reg_wr(32'h08, 32'h1F, 4'hF);

      // Randomized traffic
      rand_mode = 1;
      for (int i = 0; i < 400; i++) begin
         off = $urandom_range(0, 7);
         if ($urandom_range(0, 3) == 0) tick();
         reg_access(1'($urandom_range(0, 1)),
                    {$urandom_range(0, 255) << 8, 8'(off << 2) | 8'($urandom_range(0, 3))} >> 0,
                    (off == 1) ? 32'($urandom_range(0, 300)) : $urandom,
                    4'($urandom_range(0, 15)), d, e);
      end
      rand_mode = 0;
      evt = '0;

      // Reset during the response cycle
      reg_wr(32'h0C, 32'h1F, 4'hF);
      reg_wr(32'h00, 32'h8000_0000, 4'hF);
      evt = 4'b1000; tick(); evt = '0;
      tick();
      req.valid = 1'b1; req.write = 1'b0; req.addr = 32'h08;
      tick();
      rst_n = 1'b0;
      #1;
      check("midrst_ready", 32'(resp.ready), 32'h0);
      check("midrst_irq", 32'(irq), 32'h0);
      check("midrst_inact", 32'(inactive), 32'h0);
      model_reset();
      req = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      reg_rd_chk("post_ctrl", 32'h00, 32'h0);
      reg_rd_chk("post_lowwm", 32'h04, 32'h0);
      reg_rd_chk("post_status", 32'h08, 32'h0);
      reg_rd_chk("post_enable", 32'h0C, 32'h0);
      reg_rd_chk("post_evtcnt", 32'h14, 32'h0);

      // ---------------- final report ----------------
      if (exp_q.size() != 0) check("rsp_missing", 32'(exp_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
